// File: rtl/apb_master_bridge_if.sv
// Command/response streams and APB bus signals of apb_master_bridge.
// The master modport is the bridge side; the slave modport is its environment.
interface apb_master_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_write;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        input  cmd_valid, cmd_addr, cmd_write, cmd_wdata, rsp_ready,
               PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_write, cmd_wdata, rsp_ready,
               PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB master: valid/ready command in, APB SETUP/ACCESS out,
// valid/ready response back, with wait states, PREADY timeout and misalignment rejection.
module apb_master_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input logic                 PCLK,
    input logic                 PRESETn,
    apb_master_bridge_if.master bus
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic              r_write;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic              r_tmo;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_accept;
    logic              w_misalign;
    logic              w_abort;

    always_comb begin
        w_accept   = (r_state == IDLE) && bus.cmd_valid;
        w_misalign = (bus.cmd_addr[1:0] != 2'b00);
        // PREADY takes priority over an expiring counter in the same cycle
        w_abort    = (r_state == ACCESS) && !bus.PREADY && (TIMEOUT != 0) && (r_cnt == TMO_LIMIT);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_misalign ? RESP : SETUP;
            SETUP:   w_next = ACCESS;
            ACCESS:  if (bus.PREADY || w_abort) w_next = RESP;
            RESP:    if (bus.rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_tmo   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (w_accept && !w_misalign) begin
                r_addr  <= bus.cmd_addr;
                r_write <= bus.cmd_write;
                r_wdata <= bus.cmd_wdata;
                r_cnt   <= '0;
            end
            if (w_accept && w_misalign) begin
                r_rdata <= '0;
                r_err   <= 1'b1;
                r_tmo   <= 1'b0;
            end
            if (r_state == ACCESS) begin
                if (bus.PREADY) begin
                    r_rdata <= r_write ? '0 : bus.PRDATA;
                    r_err   <= bus.PSLVERR;
                    r_tmo   <= 1'b0;
                end else if (w_abort) begin
                    r_rdata <= '0;
                    r_err   <= 1'b1;
                    r_tmo   <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            if (r_state == RESP && bus.rsp_ready) begin
                r_rdata <= '0;
                r_err   <= 1'b0;
                r_tmo   <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.cmd_ready   = (r_state == IDLE);
        bus.PSEL        = (r_state == SETUP) || (r_state == ACCESS);
        bus.PENABLE     = (r_state == ACCESS);
        bus.PADDR       = r_addr;
        bus.PWRITE      = r_write;
        bus.PWDATA      = r_wdata;
        bus.rsp_valid   = (r_state == RESP);
        bus.rsp_rdata   = r_rdata;
        bus.rsp_err     = r_err;
        bus.rsp_timeout = r_tmo;
    end
endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge (TIMEOUT=4) against a small register-map
// slave model with programmable wait states, forced PSLVERR and stuck-low PREADY.
module tb_apb_master_bridge;
    logic PCLK;
    logic PRESETn;
    int   n_chk;
    int   n_err;

    apb_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) u_dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // slave model controls
    int          wait_n;
    logic        stuck;
    logic        force_err;
    int          acc_low;
    logic [31:0] reg_ctrl;
    logic [31:0] reg_data;

    // monitor totals (snapshotted by the stimulus, never written by it)
    int          acc_total;
    int          setup_total;
    int          stable_bad;
    logic [31:0] mon_addr;
    logic [31:0] mon_wdata;

    always_comb begin
        bus.PREADY  = !stuck && (acc_low >= wait_n);
        bus.PSLVERR = force_err && bus.PREADY;
        case (bus.PADDR)
            32'h00:  bus.PRDATA = 32'hDEADBEEF;
            32'h04:  bus.PRDATA = reg_ctrl;
            32'h08:  bus.PRDATA = {31'b0, reg_ctrl[0]};
            32'h0C:  bus.PRDATA = reg_data;
            default: bus.PRDATA = 32'h0;
        endcase
    end

    initial begin
        reg_ctrl = '0;
        reg_data = '0;
        acc_low  = 0;
    end

    always @(posedge PCLK) begin
        if (bus.PSEL && bus.PENABLE) begin
            if (bus.PREADY) begin
                acc_low <= 0;
                if (bus.PWRITE && !bus.PSLVERR) begin
                    if (bus.PADDR == 32'h04) reg_ctrl <= bus.PWDATA;
                    if (bus.PADDR == 32'h0C) reg_data <= bus.PWDATA;
                end
            end else begin
                acc_low <= acc_low + 1;
            end
        end else begin
            acc_low <= 0;
        end
    end

    initial begin
        acc_total   = 0;
        setup_total = 0;
        stable_bad  = 0;
    end

    always @(posedge PCLK) begin
        if (bus.PSEL && bus.PENABLE) begin
            acc_total <= acc_total + 1;
            if (bus.PADDR !== mon_addr || bus.PWDATA !== mon_wdata)
                stable_bad <= stable_bad + 1;
        end
        if (bus.PSEL && !bus.PENABLE) setup_total <= setup_total + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic xfer(input string tag, input logic [31:0] addr, input logic wr,
                        input logic [31:0] wd, input int hold,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input logic exp_tmo, input int exp_lat, input int exp_acc);
        int lat;
        int acc0;
        int set0;
        int bad0;
        logic aligned;
        aligned   = (addr[1:0] == 2'b00);
        acc0      = acc_total;
        set0      = setup_total;
        bad0      = stable_bad;
        mon_addr  = addr;
        mon_wdata = wd;
        bus.cmd_addr  = addr;
        bus.cmd_write = wr;
        bus.cmd_wdata = wd;
        bus.cmd_valid = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        lat = 1;
        if (aligned) begin
            chk({tag, "_setup_psel"}, 32'(bus.PSEL), 32'd1);
            chk({tag, "_setup_penable"}, 32'(bus.PENABLE), 32'd0);
            chk({tag, "_setup_paddr"}, bus.PADDR, addr);
            chk({tag, "_setup_pwrite"}, 32'(bus.PWRITE), 32'(wr));
        end else begin
            chk({tag, "_no_psel"}, 32'(bus.PSEL), 32'd0);
        end
        while (!bus.rsp_valid && lat < 200) begin
            step();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_rdata"}, bus.rsp_rdata, exp_rdata);
        chk({tag, "_err"}, 32'(bus.rsp_err), 32'(exp_err));
        chk({tag, "_timeout"}, 32'(bus.rsp_timeout), 32'(exp_tmo));
        chk({tag, "_access_cycles"}, 32'(acc_total - acc0), 32'(exp_acc));
        chk({tag, "_setup_cycles"}, 32'(setup_total - set0), aligned ? 32'd1 : 32'd0);
        chk({tag, "_addr_data_stable"}, 32'(stable_bad - bad0), 32'd0);
        chk({tag, "_resp_psel"}, 32'(bus.PSEL), 32'd0);
        chk({tag, "_resp_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            step();
            chk({tag, "_hold_valid"}, 32'(bus.rsp_valid), 32'd1);
            chk({tag, "_hold_err"}, 32'(bus.rsp_err), 32'(exp_err));
            chk({tag, "_hold_rdata"}, bus.rsp_rdata, exp_rdata);
            chk({tag, "_hold_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
            chk({tag, "_hold_psel"}, 32'(bus.PSEL), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        chk({tag, "_idle_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        chk({tag, "_idle_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        PRESETn       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_write = 1'b0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        wait_n    = 0;
        stuck     = 1'b0;
        force_err = 1'b0;
        mon_addr  = '0;
        mon_wdata = '0;
        #3;
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_psel", 32'(bus.PSEL), 32'd0);
        chk("rst_penable", 32'(bus.PENABLE), 32'd0);
        chk("rst_pwrite", 32'(bus.PWRITE), 32'd0);
        chk("rst_paddr", bus.PADDR, 32'd0);
        chk("rst_pwdata", bus.PWDATA, 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
        step();
        step();
        PRESETn = 1'b1;
        step();

        xfer("rd_id", 32'h00, 1'b0, 32'h0, 0, 32'hDEADBEEF, 1'b0, 1'b0, 3, 1);
        xfer("wr_ctrl", 32'h04, 1'b1, 32'h00000001, 0, 32'h0, 1'b0, 1'b0, 3, 1);
        xfer("rd_status", 32'h08, 1'b0, 32'h0, 0, 32'h00000001, 1'b0, 1'b0, 3, 1);
        xfer("wr_data", 32'h0C, 1'b1, 32'hA5A5A5A5, 0, 32'h0, 1'b0, 1'b0, 3, 1);
        xfer("rd_data", 32'h0C, 1'b0, 32'h0, 0, 32'hA5A5A5A5, 1'b0, 1'b0, 3, 1);

        wait_n = 3;
        force_err = 1'b1;
        xfer("wait3_slverr", 32'h0C, 1'b1, 32'h12345678, 0, 32'h0, 1'b1, 1'b0, 6, 4);
        force_err = 1'b0;

        stuck = 1'b1;
        xfer("timeout", 32'h00, 1'b0, 32'h0, 0, 32'h0, 1'b1, 1'b1, 7, 5);
        stuck = 1'b0;

        wait_n = 4;
        xfer("ready_at_limit", 32'h00, 1'b0, 32'h0, 0, 32'hDEADBEEF, 1'b0, 1'b0, 7, 5);
        wait_n = 0;

        xfer("misaligned", 32'h06, 1'b0, 32'h0, 10, 32'h0, 1'b1, 1'b0, 1, 0);

        // reset while a read is stuck in ACCESS
        stuck = 1'b1;
        bus.cmd_addr  = 32'h00;
        bus.cmd_write = 1'b0;
        bus.cmd_wdata = 32'h0;
        mon_addr  = 32'h00;
        mon_wdata = 32'h0;
        bus.cmd_valid = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        step();
        step();
        chk("mid_access_penable", 32'(bus.PENABLE), 32'd1);
        #2;
        PRESETn = 1'b0;
        #1;
        chk("arst_psel", 32'(bus.PSEL), 32'd0);
        chk("arst_penable", 32'(bus.PENABLE), 32'd0);
        chk("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("arst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        step();
        step();
        PRESETn = 1'b1;
        stuck = 1'b0;
        step();
        chk("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        step();
        chk("post_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        xfer("rd_after_rst", 32'h00, 1'b0, 32'h0, 0, 32'hDEADBEEF, 1'b0, 1'b0, 3, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
